imem_access_arbiter: RTL and testbench
======================================

Name: imem_access_arbiter

Overview:
- Sequences and shares the byte-wide instruction memory between two requesters: the IF-stage fetch port (32-bit reads) and the program-loader port (32-bit writes).
- Converts each 32-bit request into four byte accesses, big-endian: byte at address+0 is bits [31:24].
- Arbitrates round-robin between the two ports and returns a one-cycle ack per completed transaction.
- Sits between the IF stage / boot loader and the instruction memory byte array.

Parameters:
ADDR_W, 32, width of byte addresses on all ports
DATA_W, 32, instruction word width; fixed at 4 bytes
BYTE_W, 8, memory byte width

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, synchronous, active-high
f_req  in  1  fetch read request; held until f_ack
f_addr  in  ADDR_W  fetch byte address; bits [1:0] ignored
f_ack  out  1  one-cycle pulse; f_rdata valid in the same cycle
f_rdata  out  DATA_W  fetched word, held until the next fetch ack
l_req  in  1  loader write request; held until l_ack
l_addr  in  ADDR_W  loader byte address; bits [1:0] ignored
l_wdata  in  DATA_W  word to write
l_ack  out  1  one-cycle pulse when all 4 bytes are written
busy  out  1  high whenever state != IDLE
mem_addr  out  ADDR_W  byte address to memory
mem_re  out  1  byte read strobe
mem_we  out  1  byte write strobe
mem_wdata  out  BYTE_W  byte to write
mem_rdata  in  BYTE_W  read byte; valid 1 cycle after mem_re

Behaviour:
- Reset values: state IDLE, all outputs 0, byte counter 0, last_grant = FETCH.
- A request is sampled in IDLE only.
- Address word base is {addr[ADDR_W-1:2], 2'b00}.
- Arbitration in IDLE:
  - Only one request high: grant it.
  - Both high: grant the port not equal to last_grant; update last_grant on every grant.
  - After reset, a simultaneous request therefore goes to the loader first.
- States: IDLE, RD, RD_WAIT, WR, ACK.
- Read (cycle 0 = IDLE cycle that grants):
  - Cycles 1-4 (RD): mem_re=1, mem_addr = base + k for k = 0..3.
  - Cycles 2-5: mem_rdata captured, shifted left by 8 each capture (byte k lands in bits [31-8k:24-8k]).
  - Cycle 5 (RD_WAIT): final capture.
  - Cycle 6 (ACK): f_ack=1 with f_rdata valid.
  - Fetch latency: 6 cycles from grant to ack.
- Write:
  - Cycles 1-4 (WR): mem_we=1, mem_addr = base + k, mem_wdata = l_wdata[31-8k:24-8k].
  - Cycle 5 (ACK): l_ack=1.
- Inputs are registered at grant; requester changes after grant have no effect on the transaction.
- ACK always returns to IDLE. A request still high during ACK is ignored, so there is no re-grant; the earliest next grant is the cycle after ACK.
- mem_re and mem_we are never both 1. Outside RD and WR, mem_re=mem_we=0 and mem_addr/mem_wdata hold their last value.
- Mid-operation rst:
  - Next state is IDLE; no ack is issued.
  - mem_we and mem_re are 0 from the next edge; a partial write leaves the already-written bytes modified.
  - f_rdata clears to 0; last_grant resets to FETCH.
- Word address wrap: base + 3 never carries past the word because the low bits are an explicit counter.

Test Plan:
- Memory bytes 0..3 = E0 00 00 00. f_req, f_addr=0x0 -> mem_re for addresses 0,1,2,3 in cycles 1-4; f_ack in cycle 6; f_rdata = 0xE0000000; busy high cycles 1-6.
- l_req, l_addr=0x4, l_wdata=0xE3A00014 -> mem_we with (4,E3),(5,A0),(6,00),(7,14) in cycles 1-4; l_ack in cycle 5. A following fetch of 0x7 returns 0xE3A00014 (low bits ignored).
- f_req and l_req both raised in the same cycle right after reset -> loader is granted first; the fetch is granted the cycle after l_ack; the fetch is not starved.
- Both requests held continuously for 4 transactions -> grants alternate L, F, L, F; exactly one ack per transaction; no back-to-back double grant to the same port.
- rst asserted during cycle 2 of a write to 0x8 with 0xAABBCCDD -> no l_ack; mem_we low after the edge; only bytes 8-9 modified; state IDLE; busy=0.
- f_req held high through ACK -> exactly one f_ack pulse; the next transaction starts in the cycle after ACK.

Source files
------------

// File: rtl/imem_access_arbiter.sv
// imem_access_arbiter
//   Shares the byte-wide instruction memory between the IF-stage fetch port
//   (32-bit reads) and the program-loader port (32-bit writes). Each word
//   request becomes four big-endian byte accesses (address+0 -> bits [31:24]).
//   Round-robin arbitration between the two ports; a one-cycle ack is
//   returned per completed transaction.
//
// Ports
//   clk, rst            clock (rising edge), synchronous active-high reset
//   f_req/f_addr        fetch request (held until f_ack) and byte address
//   f_ack/f_rdata       fetch done pulse; word held until the next fetch ack
//   l_req/l_addr/l_wdata loader write request (held until l_ack), address, word
//   l_ack               loader done pulse
//   busy                high whenever the sequencer is not idle
//   mem_addr/mem_re/mem_we/mem_wdata  byte-memory command (registered)
//   mem_rdata           read byte, valid one cycle after mem_re
module imem_access_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int BYTE_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_ack,
    output logic [DATA_W-1:0] f_rdata,
    input  logic              l_req,
    input  logic [ADDR_W-1:0] l_addr,
    input  logic [DATA_W-1:0] l_wdata,
    output logic              l_ack,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_re,
    output logic              mem_we,
    output logic [BYTE_W-1:0] mem_wdata,
    input  logic [BYTE_W-1:0] mem_rdata
);

    typedef enum logic [2:0] {
        IDLE,
        RD,
        RD_WAIT,
        WR,
        ACK
    } state_t;

    typedef enum logic {
        GNT_FETCH,
        GNT_LOAD
    } grant_t;

    state_t              state_q;
    grant_t              last_grant_q;
    logic [1:0]          cnt_q;
    logic [1:0]          cnt_d;
    logic [ADDR_W-3:0]   base_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W-1:0]   shift_q;
    logic [DATA_W-1:0]   f_rdata_q;
    logic                f_ack_q;
    logic                l_ack_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic                mem_re_q;
    logic                mem_we_q;
    logic [BYTE_W-1:0]   mem_wdata_q;
    logic                grant_load;
    logic                grant_fetch;

    // Word-offset bits are replaced by the byte counter.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{f_addr[1:0], l_addr[1:0]};

    // On contention the port that did not win last time is granted.
    always_comb begin
        grant_load  = l_req && (!f_req || (last_grant_q == GNT_FETCH));
        grant_fetch = f_req && !grant_load;
        cnt_d       = cnt_q + 2'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= GNT_FETCH;
            cnt_q        <= '0;
            base_q       <= '0;
            wdata_q      <= '0;
            shift_q      <= '0;
            f_rdata_q    <= '0;
            f_ack_q      <= 1'b0;
            l_ack_q      <= 1'b0;
            mem_addr_q   <= '0;
            mem_re_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_wdata_q  <= '0;
        end else begin
            f_ack_q <= 1'b0;
            l_ack_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (grant_load) begin
                        state_q      <= WR;
                        last_grant_q <= GNT_LOAD;
                        cnt_q        <= '0;
                        base_q       <= l_addr[ADDR_W-1:2];
                        mem_addr_q   <= {l_addr[ADDR_W-1:2], 2'b00};
                        mem_we_q     <= 1'b1;
                        mem_wdata_q  <= l_wdata[DATA_W-1 -: BYTE_W];
                        // Remaining bytes queue up at the top of wdata_q.
                        wdata_q      <= l_wdata << BYTE_W;
                    end else if (grant_fetch) begin
                        state_q      <= RD;
                        last_grant_q <= GNT_FETCH;
                        cnt_q        <= '0;
                        base_q       <= f_addr[ADDR_W-1:2];
                        mem_addr_q   <= {f_addr[ADDR_W-1:2], 2'b00};
                        mem_re_q     <= 1'b1;
                    end
                end
                RD: begin
                    // Read data trails the strobe by one cycle, so the first
                    // RD cycle has nothing to capture yet.
                    if (cnt_q != 2'd0) begin
                        shift_q <= {shift_q[DATA_W-BYTE_W-1:0], mem_rdata};
                    end
                    if (cnt_q == 2'd3) begin
                        mem_re_q <= 1'b0;
                        state_q  <= RD_WAIT;
                    end else begin
                        cnt_q      <= cnt_d;
                        mem_addr_q <= {base_q, cnt_d};
                    end
                end
                RD_WAIT: begin
                    f_rdata_q <= {shift_q[DATA_W-BYTE_W-1:0], mem_rdata};
                    f_ack_q   <= 1'b1;
                    state_q   <= ACK;
                end
                WR: begin
                    if (cnt_q == 2'd3) begin
                        mem_we_q <= 1'b0;
                        l_ack_q  <= 1'b1;
                        state_q  <= ACK;
                    end else begin
                        cnt_q       <= cnt_d;
                        mem_addr_q  <= {base_q, cnt_d};
                        mem_wdata_q <= wdata_q[DATA_W-1 -: BYTE_W];
                        wdata_q     <= wdata_q << BYTE_W;
                    end
                end
                ACK: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign f_ack     = f_ack_q;
    assign f_rdata   = f_rdata_q;
    assign l_ack     = l_ack_q;
    assign busy      = (state_q != IDLE);
    assign mem_addr  = mem_addr_q;
    assign mem_re    = mem_re_q;
    assign mem_we    = mem_we_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_imem_access_arbiter.sv
// tb_imem_access_arbiter
//   Directed bench for imem_access_arbiter with a 256-byte memory model
//   (registered read, one-cycle latency). Inputs are driven and outputs
//   sampled 1 time unit after each rising edge.
module tb_imem_access_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        f_req;
    logic [31:0] f_addr;
    logic        f_ack;
    logic [31:0] f_rdata;
    logic        l_req;
    logic [31:0] l_addr;
    logic [31:0] l_wdata;
    logic        l_ack;
    logic        busy;
    logic [31:0] mem_addr;
    logic        mem_re;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;

    logic [7:0]  mem [256];

    int checks   = 0;
    int failures = 0;

    imem_access_arbiter #(
        .ADDR_W(32),
        .DATA_W(32),
        .BYTE_W(8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .f_req    (f_req),
        .f_addr   (f_addr),
        .f_ack    (f_ack),
        .f_rdata  (f_rdata),
        .l_req    (l_req),
        .l_addr   (l_addr),
        .l_wdata  (l_wdata),
        .l_ack    (l_ack),
        .busy     (busy),
        .mem_addr (mem_addr),
        .mem_re   (mem_re),
        .mem_we   (mem_we),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
        if (mem_re) mem_rdata <= mem[mem_addr[7:0]];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    // Issue one fetch, wait (bounded) for its ack, compare the word.
    task automatic do_fetch(input logic [31:0] a, input logic [31:0] exp, input string tag);
        bit seen = 0;
        f_req  = 1'b1;
        f_addr = a;
        for (int i = 0; i < 20 && !seen; i++) begin
            step();
            if (f_ack) seen = 1;
        end
        f_req = 1'b0;
        check({tag, "_ack_seen"}, 32'(seen), 32'd1);
        check({tag, "_rdata"}, f_rdata, exp);
        step();
    endtask

    initial begin
        bit         seen;
        int         grants;
        int         acks;
        logic [3:0] seq;
        logic       prev_busy;
        int         stray;

        rst = 1'b1; f_req = 1'b0; f_addr = '0; l_req = 1'b0; l_addr = '0; l_wdata = '0;
        mem_rdata = '0;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[0] = 8'hE0;
        mem[8] = 8'h11; mem[9] = 8'h11; mem[10] = 8'h11; mem[11] = 8'h11;

        do_reset();
        check("rst_busy", 32'(busy), 0);
        check("rst_f_ack", 32'(f_ack), 0);
        check("rst_l_ack", 32'(l_ack), 0);
        check("rst_mem_re", 32'(mem_re), 0);
        check("rst_mem_we", 32'(mem_we), 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_f_rdata", f_rdata, 0);

        // Fetch of word 0, cycle-accurate; f_req kept high through ACK.
        f_req = 1'b1; f_addr = 32'h0;
        for (int c = 1; c <= 6; c++) begin
            step();
            check($sformatf("rd_c%0d_busy", c), 32'(busy), 1);
            check($sformatf("rd_c%0d_re", c), 32'(mem_re), (c <= 4) ? 1 : 0);
            check($sformatf("rd_c%0d_we", c), 32'(mem_we), 0);
            if (c <= 4) check($sformatf("rd_c%0d_addr", c), mem_addr, 32'(c - 1));
            check($sformatf("rd_c%0d_ack", c), 32'(f_ack), (c == 6) ? 1 : 0);
        end
        check("rd_word", f_rdata, 32'hE000_0000);
        step();
        check("hold_c7_busy", 32'(busy), 0);
        check("hold_c7_ack", 32'(f_ack), 0);
        step();
        check("hold_c8_regrant", 32'(mem_re), 1);
        check("hold_c8_addr", mem_addr, 32'h0);
        f_req = 1'b0;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            step();
            if (f_ack) seen = 1;
        end
        check("hold_second_ack", 32'(seen), 1);
        step();
        check("hold_no_third", 32'(busy | f_ack), 0);

        // Loader write of 0xE3A00014 to 0x4.
        l_req = 1'b1; l_addr = 32'h4; l_wdata = 32'hE3A0_0014;
        for (int c = 1; c <= 5; c++) begin
            step();
            if (c <= 4) begin
                check($sformatf("wr_c%0d_we", c), 32'(mem_we), 1);
                check($sformatf("wr_c%0d_addr", c), mem_addr, 32'(3 + c));
            end else begin
                check("wr_c5_we", 32'(mem_we), 0);
            end
            check($sformatf("wr_c%0d_re", c), 32'(mem_re), 0);
            check($sformatf("wr_c%0d_ack", c), 32'(l_ack), (c == 5) ? 1 : 0);
            case (c)
                1: check("wr_c1_data", 32'(mem_wdata), 32'hE3);
                2: check("wr_c2_data", 32'(mem_wdata), 32'hA0);
                3: check("wr_c3_data", 32'(mem_wdata), 32'h00);
                4: check("wr_c4_data", 32'(mem_wdata), 32'h14);
                default: ;
            endcase
        end
        l_req = 1'b0;
        step();
        do_fetch(32'h7, 32'hE3A0_0014, "fetch7");

        // Simultaneous requests right after reset: loader first, fetch next.
        do_reset();
        l_req = 1'b1; l_addr = 32'h10; l_wdata = 32'h0102_0304;
        f_req = 1'b1; f_addr = 32'h10;
        seen = 0;
        stray = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            step();
            if (f_ack) stray++;
            if (l_ack) seen = 1;
        end
        l_req = 1'b0;
        check("both_l_first", 32'(seen), 1);
        check("both_no_f_before_l", 32'(stray), 0);
        step();
        check("both_gap_busy", 32'(busy), 0);
        step();
        check("both_f_start", 32'(mem_re), 1);
        check("both_f_addr", mem_addr, 32'h10);
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            step();
            if (f_ack) seen = 1;
        end
        f_req = 1'b0;
        check("both_f_ack", 32'(seen), 1);
        check("both_f_rdata", f_rdata, 32'h0102_0304);
        step();

        // Both held for four transactions; last grant was FETCH.
        l_req = 1'b1; l_addr = 32'h20; l_wdata = 32'hCAFE_F00D;
        f_req = 1'b1; f_addr = 32'h20;
        grants = 0; acks = 0; seq = '0; prev_busy = busy;
        for (int i = 0; i < 80 && acks < 4; i++) begin
            step();
            if (busy && !prev_busy) grants++;
            prev_busy = busy;
            if (f_ack) begin seq = {seq[2:0], 1'b0}; acks++; end
            if (l_ack) begin seq = {seq[2:0], 1'b1}; acks++; end
            if (acks == 4) begin l_req = 1'b0; f_req = 1'b0; end
        end
        l_req = 1'b0; f_req = 1'b0;
        check("rr_ack_count", 32'(acks), 4);
        check("rr_grant_count", 32'(grants), 4);
        check("rr_order_LFLF", 32'(seq), 32'hA);
        check("rr_f_rdata", f_rdata, 32'hCAFE_F00D);
        step();
        check("rr_idle_after", 32'(busy), 0);

        // Reset during cycle 2 of a write to 0x8.
        l_req = 1'b1; l_addr = 32'h8; l_wdata = 32'hAABB_CCDD;
        step();
        check("abort_c1_we", 32'(mem_we), 1);
        check("abort_c1_addr", mem_addr, 32'h8);
        step();
        check("abort_c2_addr", mem_addr, 32'h9);
        check("abort_c2_data", 32'(mem_wdata), 32'hBB);
        rst = 1'b1;
        step();
        rst = 1'b0; l_req = 1'b0;
        check("abort_we_low", 32'(mem_we), 0);
        check("abort_busy", 32'(busy), 0);
        check("abort_f_rdata", f_rdata, 0);
        stray = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (l_ack || busy) stray++;
        end
        check("abort_no_ack", 32'(stray), 0);
        check("abort_mem8", 32'(mem[8]), 32'hAA);
        check("abort_mem9", 32'(mem[9]), 32'hBB);
        check("abort_mem10", 32'(mem[10]), 32'h11);
        check("abort_mem11", 32'(mem[11]), 32'h11);
        do_fetch(32'h8, 32'hAABB_1111, "abort_readback");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
